// File: rtl/sa_sc_fifo_lvl_pkg.sv
// Shared types and parameter checks for the show-ahead single-clock FIFO.
package fifo_pkg;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Thresholds must lie within the reachable usedw range for the given depth.
  function automatic bit thr_legal(input int aw, input int afull, input int aempty);
    return (afull >= 1) && (afull <= (1 << aw)) &&
           (aempty >= 0) && (aempty <= (1 << aw) - 1);
  endfunction

endpackage

// File: rtl/sa_sc_fifo_lvl_ram.sv
// Simple dual-port RAM, registered read, old data returned on read-during-write.
module sdp_ram_oldrdw #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= d;
    q <= mem[raddr];
  end

endmodule

// File: rtl/sa_sc_fifo_lvl.sv
// Show-ahead single-clock FIFO with level flags, usedw and sticky error flags.
module sa_sc_fifo_lvl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AFULL_THR  = 2**ADDR_WIDTH - 1,
  parameter int AEMPTY_THR = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclr,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  we,
  input  logic                  ack,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  overflow,
  output logic                  underflow
);

  if (!thr_legal(ADDR_WIDTH, AFULL_THR, AEMPTY_THR)) begin : g_bad_thr
    $error("sa_sc_fifo_lvl: AFULL_THR/AEMPTY_THR out of range");
  end

  localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH+1)'(AFULL_THR);
  localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH+1)'(AEMPTY_THR);

  logic [ADDR_WIDTH:0] wptr, rptr;
  logic [ADDR_WIDTH:0] wptr_next, rptr_next, usedw_next;
  logic                ack_eff, we_eff, clr, ram_we;
  fifo_err_t           err;

  always_comb begin
    clr        = ~rst_n | sclr;
    ack_eff    = ack & ~empty;
    we_eff     = we & (~full | ack_eff);
    ram_we     = we_eff & ~clr;
    wptr_next  = wptr + {{ADDR_WIDTH{1'b0}}, we_eff};
    rptr_next  = rptr + {{ADDR_WIDTH{1'b0}}, ack_eff};
    usedw_next = wptr_next - rptr_next;
  end

  // Read address runs one step ahead so q already shows the new head after an ack.
  sdp_ram_oldrdw #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .d     (d),
    .raddr (rptr_next[ADDR_WIDTH-1:0]),
    .q     (q)
  );

  // empty compares the current wptr so a fresh word only shows once the RAM read has caught up.
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr         <= '0;
      rptr         <= '0;
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      err          <= '0;
    end else begin
      wptr          <= wptr_next;
      rptr          <= rptr_next;
      usedw         <= usedw_next;
      empty         <= (wptr == rptr_next);
      full          <= ({~wptr_next[ADDR_WIDTH], wptr_next[ADDR_WIDTH-1:0]} == rptr_next);
      almost_full   <= (usedw_next >= AFULL_L);
      almost_empty  <= (usedw_next <= AEMPTY_L);
      err.overflow  <= err.overflow  | (we & ~we_eff);
      err.underflow <= err.underflow | (ack & empty);
    end
  end

  assign overflow  = err.overflow;
  assign underflow = err.underflow;

endmodule

// File: tb/tb_sa_sc_fifo_lvl.sv
// Directed bench for sa_sc_fifo_lvl with a queue-based reference model.
module tb_sa_sc_fifo_lvl;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclr = 1'b0;
  logic [DW-1:0] d = '0;
  logic          we = 1'b0;
  logic          ack = 1'b0;
  logic [DW-1:0] q;
  logic          empty, full, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   usedw;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  sa_sc_fifo_lvl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AFULL_THR  (3),
    .AEMPTY_THR (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclr         (sclr),
    .d            (d),
    .we           (we),
    .ack          (ack),
    .q            (q),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .usedw        (usedw),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words; the visible-empty flag ignores the word written this cycle.
  logic [DW-1:0] mq[$];
  bit m_empty = 1'b1;
  bit m_ov = 1'b0;
  bit m_un = 1'b0;

  always @(posedge clk) begin
    bit a_ok, w_ok;
    if (!rst_n || sclr) begin
      mq.delete();
      m_empty = 1'b1;
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      a_ok = ack && !m_empty;
      w_ok = we && ((mq.size() < DEPTH) || a_ok);
      if (we && !w_ok) m_ov = 1'b1;
      if (ack && m_empty) m_un = 1'b1;
      if (a_ok) void'(mq.pop_front());
      m_empty = (mq.size() == 0);
      if (w_ok) mq.push_back(d);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_empty", int'(empty), int'(m_empty));
      chk("m_full", int'(full), int'(mq.size() == DEPTH));
      chk("m_usedw", int'(usedw), mq.size());
      chk("m_afull", int'(almost_full), int'(mq.size() >= 3));
      chk("m_aempty", int'(almost_empty), int'(mq.size() <= 1));
      chk("m_overflow", int'(overflow), int'(m_ov));
      chk("m_underflow", int'(underflow), int'(m_un));
      if (!m_empty) chk("m_q", int'(q), int'(mq[0]));
    end
  end

  task automatic step(input bit w, input logic [DW-1:0] dv, input bit a, input bit c);
    we = w; d = dv; ack = a; sclr = c;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0; ack = 1'b0; sclr = 1'b0;
  endtask

  task automatic fill4(input logic [DW-1:0] base);
    for (int unsigned i = 0; i < 4; i++) step(1'b1, base + DW'(i), 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    @(negedge clk);
    step(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_usedw", int'(usedw), 0);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);

    // first-word latency
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("lat_usedw1", int'(usedw), 1);
    chk("lat_empty1", int'(empty), 1);
    chk("lat_aempty1", int'(almost_empty), 1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("lat_q2", int'(q), 'hA5);
    chk("lat_empty2", int'(empty), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("lat_drain_empty", int'(empty), 1);

    // fill, overflow, drain
    step(1'b0, '0, 1'b0, 1'b1);
    for (int unsigned i = 1; i <= 4; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 3) begin
        chk("fill_afull3", int'(almost_full), 1);
        chk("fill_full3", int'(full), 0);
      end
    end
    chk("fill_full4", int'(full), 1);
    step(1'b1, 8'h05, 1'b0, 1'b0);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_usedw", int'(usedw), 4);
    for (int unsigned i = 1; i <= 4; i++) begin
      chk("drain_q", int'(q), int'(i));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drain_empty", int'(empty), 1);

    // write+ack on full
    step(1'b0, '0, 1'b0, 1'b1);
    fill4(8'h10);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("wa_q_before", int'(q), 'h10);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("wa_full", int'(full), 1);
    chk("wa_usedw", int'(usedw), 4);
    chk("wa_q_after", int'(q), 'h11);
    chk("wa_ovf", int'(overflow), 0);
    for (int unsigned i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("wa_empty", int'(empty), 1);

    // underflow then normal traffic
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("unf_flag", int'(underflow), 1);
    chk("unf_usedw", int'(usedw), 0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("unf_q", int'(q), 'h3C);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("unf_empty", int'(empty), 1);

    // streaming across pointer wrap
    step(1'b0, '0, 1'b0, 1'b1);
    k = 0;
    for (int unsigned i = 0; i < 40 && k < 10; i++) begin
      bit a;
      a = !empty;
      if (a) begin
        chk("stream_q", int'(q), k);
        k++;
      end
      step(i < 10, DW'(i), a, 1'b0);
    end
    chk("stream_count", k, 10);
    chk("stream_empty", int'(empty), 1);

    // sclr with we, overflow set, 3 words stored
    step(1'b0, '0, 1'b0, 1'b1);
    fill4(8'h20);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("sclr_pre_usedw", int'(usedw), 3);
    chk("sclr_pre_ovf", int'(overflow), 1);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("sclr_empty", int'(empty), 1);
    chk("sclr_usedw", int'(usedw), 0);
    chk("sclr_ovf", int'(overflow), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("sclr_discard_usedw", int'(usedw), 0);
    chk("sclr_discard_empty", int'(empty), 1);

    // rst_n mid-operation with a write pending
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 8'h43, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("rst_mid_usedw", int'(usedw), 0);
    chk("rst_mid_empty", int'(empty), 1);
    chk("rst_mid_ovf", int'(overflow), 0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_mid_q", int'(q), 'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sa_sc_fifo_lvl.md
SA_SC_FIFO_LVL -- requirements
Module: sa_sc_fifo_lvl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning depth = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter AFULL_THR, default 2**ADDR_WIDTH-1, meaning almost_full level; legal range 1..2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter AEMPTY_THR, default 1, meaning almost_empty level; legal range 0..2**ADDR_WIDTH-1.
REQ-005 Port clk, input, 1 bit: single clock, rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port sclr, input, 1 bit: synchronous clear, active-high.
REQ-008 Port d, input, DATA_WIDTH bits: write data.
REQ-009 Port we, input, 1 bit: write request.
REQ-010 Port ack, input, 1 bit: read acknowledge; consumes the word currently on q.
REQ-011 Port q, output, DATA_WIDTH bits: show-ahead head-of-queue data.
REQ-012 Port empty, output, 1 bit: no word available on q.
REQ-013 Port full, output, 1 bit: all 2**ADDR_WIDTH slots occupied.
REQ-014 Port almost_full, output, 1 bit: usedw >= AFULL_THR.
REQ-015 Port almost_empty, output, 1 bit: usedw <= AEMPTY_THR.
REQ-016 Port usedw, output, ADDR_WIDTH+1 bits: occupied words, 0..2**ADDR_WIDTH.
REQ-017 Port overflow, output, 1 bit: sticky, a write was dropped.
REQ-018 Port underflow, output, 1 bit: sticky, an ack was ignored.

Function
REQ-019 Pointers SHALL be ADDR_WIDTH+1 bits; the MSB distinguishes full from empty on wrap-around.
REQ-020 The effective ack SHALL be ack_eff = ack & ~empty.
REQ-021 The effective write SHALL be we_eff = we & (~full | ack_eff); a write accepted while full with ack_eff reuses the slot being freed.
REQ-022 Only we_eff/ack_eff SHALL advance wptr/rptr, write RAM, or change usedw.
REQ-023 Latencies: we->q 2 cycles, we->empty 2, we->full 1, we->usedw/almost flags 1; ack->q 1, ack->empty/full/usedw/almost flags 1.
REQ-024 empty SHALL register (wptr == rptr_next); full SHALL register ({~wptr_next MSB, wptr_next LSBs} == rptr_next).
REQ-025 usedw SHALL register wptr_next - rptr_next, modulo 2**(ADDR_WIDTH+1); almost_full/almost_empty SHALL be registered compares of that same next value.
REQ-026 usedw SHALL count accepted words, so for one cycle after a write into an empty FIFO, usedw = 1 while empty = 1.
REQ-027 RAM SHALL be synchronous simple dual-port with old-data read-during-write; the read address SHALL be rptr_next.
REQ-028 overflow SHALL set on cycles where we & ~we_eff; underflow SHALL set on cycles where ack & empty; both SHALL hold until reset/sclr.
REQ-029 Simultaneous we_eff and ack_eff SHALL leave usedw, full, and empty unchanged except for the 2-cycle empty latency on first data.
REQ-030 sclr SHALL take priority over we/ack in the same cycle.

Reset
REQ-031 On rst_n low at a clk edge, or sclr high: pointers 0, usedw 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0.
REQ-032 q SHALL NOT be reset; its value is don't-care while empty = 1.
REQ-033 A reset or sclr asserted mid-operation SHALL discard all stored words; a we in that cycle SHALL be dropped without setting overflow.

Structure
REQ-034 Package fifo_pkg SHALL hold typedef fifo_err_t (packed struct {overflow, underflow}) and a function checking threshold legality, used by an elaboration-time assertion.
REQ-035 RAM SHALL be the sub-module sdp_ram_oldrdw (DATA_WIDTH, ADDR_WIDTH; ports clk, we, waddr, d, raddr, q), and no reset SHALL be applied to the storage.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, AFULL_THR=3, AEMPTY_THR=1)
REQ-036 Reset, then we with d=0xA5 at cycle 0 -> usedw=1 and almost_empty=1 at cycle 1; q=0xA5 and empty=0 at cycle 2.
REQ-037 Write 0x01..0x04, then a 5th write with 0x05 -> almost_full at cycle 3, full at cycle 4; 5th write dropped; overflow=1; usedw=4; drain yields 0x01..0x04.
REQ-038 Full FIFO, we with d=0x55 and ack in the same cycle -> both accepted; full stays 1; usedw=4; q advances one word; overflow unchanged.
REQ-039 ack while empty -> underflow=1; usedw=0; a subsequent write/read of 0x3C behaves normally.
REQ-040 Stream 0x00..0x09 with continuous ack once non-empty -> q order preserved across pointer wrap; empty=1 one cycle after the last ack.
REQ-041 3 words stored, overflow set, assert sclr together with we -> next cycle empty=1, usedw=0, overflow=0, and the write is discarded.
